// File: rtl/dual_issue_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// dual_issue_hazard_ctrl
//
// Hazard and issue controller for the dual-issue front end. It drives the
// per-slot enable/clear of the fetch-to-decode register, the PC stall and the
// decode-to-execute bubbles. The block resolves three hazard types:
//   - Intra-pair RAW dependencies: the pair is split, so slot 2 issues one
//     cycle after slot 1.
//   - Load-use hazards: the pipe stalls for one cycle.
//   - Taken branches and jumps: the pipe is flushed.
// The whole pipe is frozen while the memory stage reports busy.
//
// Decisions are combinational from the current state and the inputs. Only the
// FSM state and the performance counters are registered. No output feeds back
// into the decision logic.
//
// Configuration macro: DUAL_ISSUE_PERF_EN
//   Defined   : builds three 32-bit saturating performance counters.
//   Undefined : the counter ports are tied to 0 and no counter flops exist.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   RegWriteD1, RdD1                slot-1 decode write enable / destination
//   Rs1D1, Rs2D1, Rs1D2, Rs2D2      decode source registers, both slots
//   MemReadE1/2, RdE1/2             execute-stage load flags / destinations
//   PCSrcE                          taken branch/jump resolved in execute
//   MemBusyM                        data memory not ready
//   StallF                          hold the PC
//   EnFD1/2, RstFD1/2               fetch-to-decode slot enable / sync clear
//   FlushE1/2                       decode-to-execute bubble per slot
//   FreezeBE                        hold decode-to-execute and later stages
//   SplitCount, LoadStallCount,
//   FlushCount                      performance counters
// -----------------------------------------------------------------------------
module dual_issue_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteD1,
    input  logic [4:0]  RdD1,
    input  logic [4:0]  Rs1D1,
    input  logic [4:0]  Rs2D1,
    input  logic [4:0]  Rs1D2,
    input  logic [4:0]  Rs2D2,
    input  logic        MemReadE1,
    input  logic        MemReadE2,
    input  logic [4:0]  RdE1,
    input  logic [4:0]  RdE2,
    input  logic        PCSrcE,
    input  logic        MemBusyM,
    output logic        StallF,
    output logic        EnFD1,
    output logic        EnFD2,
    output logic        RstFD1,
    output logic        RstFD2,
    output logic        FlushE1,
    output logic        FlushE2,
    output logic        FreezeBE,
    output logic [31:0] SplitCount,
    output logic [31:0] LoadStallCount,
    output logic [31:0] FlushCount
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] SPLIT   = 2'd1;
    localparam logic [1:0] LDSTALL = 2'd2;
    localparam logic [1:0] FREEZE  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;

    logic pair_hazard;
    logic load_use;
    logic take_freeze;
    logic take_redirect;
    logic take_ldstall;
    logic take_split;

    // A load in execute is a hazard only if it writes a real register that
    // one of the four decode sources reads.
    function automatic logic load_hits(input logic       is_load,
                                       input logic [4:0] rd_e,
                                       input logic [4:0] s0,
                                       input logic [4:0] s1,
                                       input logic [4:0] s2,
                                       input logic [4:0] s3);
        return is_load && (rd_e != 5'd0) &&
               ((rd_e == s0) || (rd_e == s1) || (rd_e == s2) || (rd_e == s3));
    endfunction

    assign load_use = load_hits(MemReadE1, RdE1, Rs1D1, Rs2D1, Rs1D2, Rs2D2) ||
                      load_hits(MemReadE2, RdE2, Rs1D1, Rs2D1, Rs1D2, Rs2D2);

    // In SPLIT the slot-1 decode entry is the bubble left behind by the split.
    // Any apparent dependency on it is stale, so the pair hazard is masked.
    assign pair_hazard = (state != SPLIT) && RegWriteD1 && (RdD1 != 5'd0) &&
                         ((Rs1D2 == RdD1) || (Rs2D2 == RdD1));

    // One-hot priority decode: freeze > redirect > load-use > pair split.
    assign take_freeze   = MemBusyM;
    assign take_redirect = !MemBusyM && PCSrcE;
    assign take_ldstall  = !MemBusyM && !PCSrcE && load_use;
    assign take_split    = !MemBusyM && !PCSrcE && !load_use && pair_hazard;

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned. Without these defaults the tool would infer a latch.
        StallF   = 1'b0;
        EnFD1    = 1'b1;
        EnFD2    = 1'b1;
        RstFD1   = 1'b0;
        RstFD2   = 1'b0;
        FlushE1  = 1'b0;
        FlushE2  = 1'b0;
        FreezeBE = 1'b0;

        if (take_freeze) begin
            StallF   = 1'b1;
            EnFD1    = 1'b0;
            EnFD2    = 1'b0;
            FreezeBE = 1'b1;
        end else if (take_redirect) begin
            // The clears take priority over the enables in the FD register.
            // Both decode and execute therefore get bubbles, while the PC
            // loads the target.
            RstFD1  = 1'b1;
            RstFD2  = 1'b1;
            FlushE1 = 1'b1;
            FlushE2 = 1'b1;
        end else if (take_ldstall) begin
            StallF  = 1'b1;
            EnFD1   = 1'b0;
            EnFD2   = 1'b0;
            FlushE1 = 1'b1;
            FlushE2 = 1'b1;
        end else if (take_split) begin
            // Slot 1 issues and its FD entry becomes a bubble. Slot 2 is held
            // in decode and issues next cycle.
            StallF  = 1'b1;
            RstFD1  = 1'b1;
            EnFD2   = 1'b0;
            FlushE2 = 1'b1;
        end

        // Reset forces the output values asynchronously, whatever the state.
        if (!rst_n) begin
            StallF   = 1'b1;
            EnFD1    = 1'b0;
            EnFD2    = 1'b0;
            RstFD1   = 1'b1;
            RstFD2   = 1'b1;
            FlushE1  = 1'b1;
            FlushE2  = 1'b1;
            FreezeBE = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = RUN;
        if (take_freeze) begin
            state_next = FREEZE;
        end else if (take_ldstall) begin
            state_next = LDSTALL;
        end else if (take_split) begin
            state_next = SPLIT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef DUAL_ISSUE_PERF_EN
    // The take_* terms are all gated by !MemBusyM, so frozen cycles never
    // count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SplitCount     <= 32'd0;
            LoadStallCount <= 32'd0;
            FlushCount     <= 32'd0;
        end else begin
            if (take_split && (SplitCount != 32'hFFFF_FFFF))
                SplitCount <= SplitCount + 32'd1;
            if (take_ldstall && (LoadStallCount != 32'hFFFF_FFFF))
                LoadStallCount <= LoadStallCount + 32'd1;
            if (take_redirect && (FlushCount != 32'hFFFF_FFFF))
                FlushCount <= FlushCount + 32'd1;
        end
    end
`else
    assign SplitCount     = 32'd0;
    assign LoadStallCount = 32'd0;
    assign FlushCount     = 32'd0;
`endif

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_hazard_ctrl
//
// Self-checking bench for dual_issue_hazard_ctrl. Directed scenarios cover
// reset, pair split, load-use, x0, redirect priority and freeze. Randomized
// cycles follow. A reference model decides the action for each cycle from
// the hazard rules. It remembers only whether the previous cycle split a
// pair, and it counts the events for the performance counters.
// -----------------------------------------------------------------------------
module tb_dual_issue_hazard_ctrl;

`ifdef DUAL_ISSUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Expected output vector: {StallF,EnFD1,EnFD2,RstFD1,RstFD2,FlushE1,FlushE2,FreezeBE}
    localparam logic [7:0] V_RESET  = 8'b1001_1110;
    localparam logic [7:0] V_FREEZE = 8'b1000_0001;
    localparam logic [7:0] V_REDIR  = 8'b0111_1110;
    localparam logic [7:0] V_LDUSE  = 8'b1000_0110;
    localparam logic [7:0] V_SPLIT  = 8'b1101_0010;
    localparam logic [7:0] V_NORMAL = 8'b0110_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteD1;
    logic [4:0]  RdD1, Rs1D1, Rs2D1, Rs1D2, Rs2D2;
    logic        MemReadE1, MemReadE2;
    logic [4:0]  RdE1, RdE2;
    logic        PCSrcE, MemBusyM;
    logic        StallF, EnFD1, EnFD2, RstFD1, RstFD2, FlushE1, FlushE2, FreezeBE;
    logic [31:0] SplitCount, LoadStallCount, FlushCount;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          prev_split = 1'b0;
    longint      m_split = 0, m_ldstall = 0, m_flush = 0;

    typedef struct {
        logic       rw;
        logic [4:0] rd_d1, rs1d1, rs2d1, rs1d2, rs2d2;
        logic       mr1, mr2;
        logic [4:0] rd_e1, rd_e2;
        logic       pcsrc, busy;
    } stim_t;

    dual_issue_hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RegWriteD1     (RegWriteD1),
        .RdD1           (RdD1),
        .Rs1D1          (Rs1D1),
        .Rs2D1          (Rs2D1),
        .Rs1D2          (Rs1D2),
        .Rs2D2          (Rs2D2),
        .MemReadE1      (MemReadE1),
        .MemReadE2      (MemReadE2),
        .RdE1           (RdE1),
        .RdE2           (RdE2),
        .PCSrcE         (PCSrcE),
        .MemBusyM       (MemBusyM),
        .StallF         (StallF),
        .EnFD1          (EnFD1),
        .EnFD2          (EnFD2),
        .RstFD1         (RstFD1),
        .RstFD2         (RstFD2),
        .FlushE1        (FlushE1),
        .FlushE2        (FlushE2),
        .FreezeBE       (FreezeBE),
        .SplitCount     (SplitCount),
        .LoadStallCount (LoadStallCount),
        .FlushCount     (FlushCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rw = 0; s.rd_d1 = 0; s.rs1d1 = 0; s.rs2d1 = 0; s.rs1d2 = 0; s.rs2d2 = 0;
        s.mr1 = 0; s.mr2 = 0; s.rd_e1 = 0; s.rd_e2 = 0; s.pcsrc = 0; s.busy = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rw    = ($urandom_range(0, 1) == 1);
        s.rd_d1 = 5'($urandom_range(0, 3));
        s.rs1d1 = 5'($urandom_range(0, 3));
        s.rs2d1 = 5'($urandom_range(0, 3));
        s.rs1d2 = 5'($urandom_range(0, 3));
        s.rs2d2 = 5'($urandom_range(0, 3));
        s.mr1   = ($urandom_range(0, 3) == 0);
        s.mr2   = ($urandom_range(0, 3) == 0);
        s.rd_e1 = 5'($urandom_range(0, 3));
        s.rd_e2 = 5'($urandom_range(0, 3));
        s.pcsrc = ($urandom_range(0, 6) == 0);
        s.busy  = ($urandom_range(0, 6) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        RegWriteD1 = s.rw;    RdD1  = s.rd_d1;
        Rs1D1 = s.rs1d1; Rs2D1 = s.rs2d1; Rs1D2 = s.rs1d2; Rs2D2 = s.rs2d2;
        MemReadE1 = s.mr1; MemReadE2 = s.mr2; RdE1 = s.rd_e1; RdE2 = s.rd_e2;
        PCSrcE = s.pcsrc; MemBusyM = s.busy;
    endtask

    function automatic logic [7:0] outs();
        return {StallF, EnFD1, EnFD2, RstFD1, RstFD2, FlushE1, FlushE2, FreezeBE};
    endfunction

    task automatic check_counters(input string tag);
        check({tag, ".split"},   SplitCount,     PERF ? 32'(m_split)   : 32'd0);
        check({tag, ".ldstall"}, LoadStallCount, PERF ? 32'(m_ldstall) : 32'd0);
        check({tag, ".flush"},   FlushCount,     PERF ? 32'(m_flush)   : 32'd0);
    endtask

    // Called just after a rising edge. It drives the inputs, checks at the
    // falling edge, then advances the model across the next rising edge.
    task automatic cycle(input string tag, input stim_t s);
        logic [4:0]  srcs [4];
        logic [4:0]  lrd  [2];
        logic        lmr  [2];
        bit          pair, lu;
        logic [7:0]  exp;
        apply(s);
        #4;
        srcs = '{s.rs1d1, s.rs2d1, s.rs1d2, s.rs2d2};
        lrd  = '{s.rd_e1, s.rd_e2};
        lmr  = '{s.mr1, s.mr2};
        lu = 0;
        foreach (lrd[x])
            foreach (srcs[k])
                if (lmr[x] && lrd[x] != 0 && lrd[x] == srcs[k]) lu = 1;
        pair = s.rw && s.rd_d1 != 0 && (s.rs1d2 == s.rd_d1 || s.rs2d2 == s.rd_d1)
               && !prev_split;
        if (s.busy)       exp = V_FREEZE;
        else if (s.pcsrc) exp = V_REDIR;
        else if (lu)      exp = V_LDUSE;
        else if (pair)    exp = V_SPLIT;
        else              exp = V_NORMAL;
        check({tag, ".outs"}, 32'(outs()), 32'(exp));
        check_counters(tag);
        @(posedge clk);
        prev_split = (exp == V_SPLIT);
        if (exp == V_SPLIT) m_split   = (m_split   < 64'hFFFF_FFFF) ? m_split + 1 : m_split;
        if (exp == V_LDUSE) m_ldstall = (m_ldstall < 64'hFFFF_FFFF) ? m_ldstall + 1 : m_ldstall;
        if (exp == V_REDIR) m_flush   = (m_flush   < 64'hFFFF_FFFF) ? m_flush + 1 : m_flush;
        #1;
    endtask

    task automatic model_reset();
        prev_split = 0; m_split = 0; m_ldstall = 0; m_flush = 0;
    endtask

    initial begin
        stim_t s;
        rst_n = 1'b0;
        apply(idle());
        #3;
        check("por.outs", 32'(outs()), 32'(V_RESET));
        check_counters("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        cycle("idle", idle());

        // Pair split, then the same pair seen again in SPLIT is masked
        s = idle(); s.rw = 1; s.rd_d1 = 5; s.rs2d2 = 5;
        cycle("split_t", s);
        cycle("split_t1", s);
        cycle("split_after", idle());

        // Load-use: one stall cycle, then normal
        s = idle(); s.mr2 = 1; s.rd_e2 = 7; s.rs1d1 = 7;
        cycle("lduse", s);
        cycle("lduse_after", idle());

        // x0 is never a hazard
        s = idle(); s.mr1 = 1; s.rd_e1 = 0; s.rw = 1; s.rd_d1 = 0; s.rs1d2 = 0;
        cycle("x0", s);
        cycle("x0_after", idle());

        // Redirect beats pair and load-use hazards
        s = idle(); s.pcsrc = 1; s.rw = 1; s.rd_d1 = 3; s.rs1d2 = 3;
        s.mr1 = 1; s.rd_e1 = 4; s.rs2d1 = 4;
        cycle("redir", s);
        cycle("redir_after", idle());

        // Freeze for 3 cycles over a pending load-use, then one stall
        s = idle(); s.mr1 = 1; s.rd_e1 = 9; s.rs2d2 = 9; s.busy = 1;
        for (int i = 0; i < 3; i++) cycle("freeze", s);
        s.busy = 0;
        cycle("freeze_rel", s);
        cycle("freeze_after", idle());

        // Split, then a load-use in SPLIT
        s = idle(); s.rw = 1; s.rd_d1 = 2; s.rs1d2 = 2;
        cycle("split_ld0", s);
        s.mr2 = 1; s.rd_e2 = 2;
        cycle("split_ld1", s);
        cycle("split_ld2", idle());

        // Asynchronous reset mid-LDSTALL
        s = idle(); s.mr1 = 1; s.rd_e1 = 6; s.rs1d2 = 6;
        cycle("pre_rst", s);
        apply(idle());
        #1;
        rst_n = 1'b0;
        #1;
        check("rst.outs", 32'(outs()), 32'(V_RESET));
        model_reset();
        check_counters("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("post_rst", idle());

        // Randomized traffic
        for (int i = 0; i < 600; i++) cycle("rand", rand_stim());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
